// File: rtl/read_engine.sv
// Streams a block of host cache lines into the AFU: requests issue one per cycle, and each response is forwarded one cycle after it arrives.
// Issue is throttled by downstream-FIFO credits and by stall. The response path is never blocked.
package read_engine_pkg;
  typedef enum logic [1:0] {
    AFU_IDLE = 2'd0,
    AFU_CTRL = 2'd1,
    AFU_RUN  = 2'd2,
    AFU_DONE = 2'd3
  } e_afu_state;
  typedef logic [41:0]  t_cci_clAddr;
  typedef logic [511:0] t_cci_clData;
endpackage

module read_engine
  import read_engine_pkg::*;
#(
  parameter int OUT_FIFO_DEPTH = 64,
  parameter int MDATA_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  e_afu_state         afu_state,
  input  logic               stall,
  input  t_cci_clAddr        rd_start_addr,
  input  logic [31:0]        rd_num_cls,
  output logic               rd_valid,
  output t_cci_clAddr        rd_addr,
  output logic [MDATA_W-1:0] rd_mdata,
  input  logic               rsp_valid,
  input  logic [MDATA_W-1:0] rsp_mdata,
  input  t_cci_clData        rsp_data,
  output logic               out_valid,
  output logic [MDATA_W-1:0] out_idx,
  output t_cci_clData        out_data,
  input  logic               out_pop,
  output logic               rd_done,
  output logic [31:0]        run_cls_rcvd
);

  localparam int CRED_W = $clog2(OUT_FIFO_DEPTH) + 1;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(OUT_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state, state_nxt;
  logic [31:0]       issued, rcvd, rcvd_nxt, num_cls;
  t_cci_clAddr       start_addr;
  logic [CRED_W-1:0] credits, credits_nxt;
  logic              in_run, start_run, issue, done_set;

  assign in_run       = (afu_state == AFU_RUN);
  assign rcvd_nxt     = rcvd + {31'b0, rsp_valid};
  assign run_cls_rcvd = rcvd;

  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (in_run) begin
          state_nxt = ISSUE;
          start_run = 1'b1;
        end
      end
      ISSUE: begin
        if (!in_run || issued >= num_cls) state_nxt = WAIT;
        else                              issue = !stall && (credits != '0);
      end
      WAIT: begin
        if (!in_run && afu_state != AFU_DONE && rcvd == issued) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Set on the same edge that enters (or stays in) WAIT, so a zero-length run reports done two cycles after AFU_RUN.
  assign done_set = (state_nxt == WAIT) && (rcvd_nxt == num_cls);

  always_comb begin
    credits_nxt = credits;
    if (issue && !out_pop)                              credits_nxt = credits - CRED_W'(1);
    else if (!issue && out_pop && credits != CRED_MAX) credits_nxt = credits + CRED_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      issued     <= '0;
      rcvd       <= '0;
      num_cls    <= '0;
      start_addr <= '0;
      credits    <= CRED_MAX;
      rd_done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      credits <= credits_nxt;
      rcvd    <= start_run ? '0 : rcvd_nxt;
      if (start_run) begin
        start_addr <= rd_start_addr;
        num_cls    <= rd_num_cls;
        issued     <= '0;
        rd_done    <= 1'b0;
      end else begin
        if (issue)    issued  <= issued + 32'd1;
        if (done_set) rd_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_addr  <= '0;
      rd_mdata <= '0;
    end else begin
      rd_valid <= issue;
      if (issue) begin
        rd_addr  <= start_addr + t_cci_clAddr'(issued);
        rd_mdata <= issued[MDATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= rsp_valid;
      if (rsp_valid) begin
        out_idx  <= rsp_mdata;
        out_data <= rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_read_engine.sv
// Bench for read_engine: a table of run vectors, randomized runs, and hand-written credit/stall/reorder/abort/reset sequences.
module tb_read_engine;
  import read_engine_pkg::*;

  localparam int MW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  e_afu_state  afu_state;
  logic        stall;
  t_cci_clAddr rd_start_addr;
  logic [31:0] rd_num_cls;
  logic        rsp_valid;
  logic [MW-1:0] rsp_mdata;
  t_cci_clData rsp_data;
  logic        out_pop;

  logic a_rd_valid, b_rd_valid, a_out_valid, b_out_valid, a_rd_done, b_rd_done;
  t_cci_clAddr a_rd_addr, b_rd_addr;
  logic [MW-1:0] a_rd_mdata, b_rd_mdata, a_out_idx, b_out_idx;
  t_cci_clData a_out_data, b_out_data;
  logic [31:0] a_rcls, b_rcls;

  read_engine #(.OUT_FIFO_DEPTH(64), .MDATA_W(MW)) u_big (
    .clk(clk), .rst_n(rst_n), .afu_state(afu_state), .stall(stall),
    .rd_start_addr(rd_start_addr), .rd_num_cls(rd_num_cls),
    .rd_valid(a_rd_valid), .rd_addr(a_rd_addr), .rd_mdata(a_rd_mdata),
    .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
    .out_valid(a_out_valid), .out_idx(a_out_idx), .out_data(a_out_data),
    .out_pop(out_pop), .rd_done(a_rd_done), .run_cls_rcvd(a_rcls));

  read_engine #(.OUT_FIFO_DEPTH(4), .MDATA_W(MW)) u_small (
    .clk(clk), .rst_n(rst_n), .afu_state(afu_state), .stall(stall),
    .rd_start_addr(rd_start_addr), .rd_num_cls(rd_num_cls),
    .rd_valid(b_rd_valid), .rd_addr(b_rd_addr), .rd_mdata(b_rd_mdata),
    .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
    .out_valid(b_out_valid), .out_idx(b_out_idx), .out_data(b_out_data),
    .out_pop(out_pop), .rd_done(b_rd_done), .run_cls_rcvd(b_rcls));

  // The instance under observation: 0 = depth 64, 1 = depth 4.
  int sel = 0;
  logic m_rd_valid, m_out_valid, m_rd_done;
  t_cci_clAddr m_rd_addr;
  logic [MW-1:0] m_rd_mdata, m_out_idx;
  t_cci_clData m_out_data;
  logic [31:0] m_rcls;

  always_comb begin
    m_rd_valid  = (sel == 1) ? b_rd_valid  : a_rd_valid;
    m_rd_addr   = (sel == 1) ? b_rd_addr   : a_rd_addr;
    m_rd_mdata  = (sel == 1) ? b_rd_mdata  : a_rd_mdata;
    m_out_valid = (sel == 1) ? b_out_valid : a_out_valid;
    m_out_idx   = (sel == 1) ? b_out_idx   : a_out_idx;
    m_out_data  = (sel == 1) ? b_out_data  : a_out_data;
    m_rd_done   = (sel == 1) ? b_rd_done   : a_rd_done;
    m_rcls      = (sel == 1) ? b_rcls      : a_rcls;
  end

  typedef struct {int idx; int cyc;} pend_t;
  pend_t pend[$];

  int checks = 0, passes = 0, cyc = 0;
  int reqs = 0, pops_applied = 0, occ = 0, depth_cur = 64, num_cur = 0;
  int first_req = -1, last_req = -1, stall_reqs = 0;
  int rsp_mode = 0, pop_mode = 0, stall_pct = 0, pop_budget = 0, rsp_last_idx = 0;
  logic stall_force = 1'b0, stall_d1 = 1'b0, stall_d2 = 1'b0, pop_last = 1'b0, rsp_last_v = 1'b0;
  t_cci_clAddr start_cur = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic t_cci_clData mk_data(input int idx);
    t_cci_clData d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = (idx * 32'h9E3779B9) ^ (i << 8) ^ 32'h5A5A0000;
    return d;
  endfunction

  task automatic send(input int k);
    int id;
    id = pend[k].idx;
    rsp_valid    = 1'b1;
    rsp_mdata    = id[MW-1:0];
    rsp_data     = mk_data(id);
    rsp_last_v   = 1'b1;
    rsp_last_idx = id;
    pend.delete(k);
  endtask

  // One clock: sample and check outputs just after the edge, then drive the next cycle's inputs.
  task automatic tick();
    t_cci_clAddr ea;
    int k;
    @(posedge clk); #1;
    cyc++;
    if (stall_d1 && stall_d2) chk("rd_valid_under_stall", m_rd_valid, 1'b0);
    if (m_rd_valid) begin
      ea = start_cur + t_cci_clAddr'(reqs);
      chk("req_credit_avail", (depth_cur - reqs + pops_applied) > 0, 1'b1);
      chk("req_within_num", reqs < num_cur, 1'b1);
      chk("rd_addr", m_rd_addr, ea);
      chk("rd_mdata", m_rd_mdata, reqs[MW-1:0]);
      if (stall_d1) stall_reqs++;
      if (first_req < 0) first_req = cyc;
      last_req = cyc;
      pend.push_back('{reqs, cyc});
      reqs++;
    end
    chk("out_valid", m_out_valid, rsp_last_v);
    if (rsp_last_v) begin
      chk("out_idx", m_out_idx, rsp_last_idx[MW-1:0]);
      chk("out_data", m_out_data == mk_data(rsp_last_idx), 1'b1);
      occ++;
    end
    if (pop_last) pops_applied++;

    rsp_valid  = 1'b0;
    rsp_last_v = 1'b0;
    k = -1;
    if (pend.size() > 0) begin
      if (rsp_mode == 1 && cyc - pend[0].cyc >= 1) k = 0;
      else if (rsp_mode == 2 && $urandom_range(0, 2) == 0) k = $urandom_range(0, pend.size() - 1);
    end
    if (k >= 0) send(k);

    out_pop = 1'b0;
    if (occ > 0) begin
      if (pop_mode == 1 && $urandom_range(0, 1) == 1) out_pop = 1'b1;
      else if (pop_mode == 2 && pop_budget > 0) begin
        out_pop = 1'b1;
        pop_budget--;
      end
    end
    if (out_pop) occ--;
    pop_last = out_pop;

    stall    = stall_force || (stall_pct > 0 && $urandom_range(0, 99) < stall_pct);
    stall_d2 = stall_d1;
    stall_d1 = stall;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    afu_state = AFU_CTRL; stall = 1'b0; rsp_valid = 1'b0; out_pop = 1'b0;
    rsp_mdata = '0; rsp_data = '0; rd_start_addr = '0; rd_num_cls = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pend.delete();
    reqs = 0; pops_applied = 0; occ = 0; stall_reqs = 0; pop_budget = 0;
    rsp_mode = 0; pop_mode = 0; stall_pct = 0;
    stall_force = 1'b0; stall_d1 = 1'b0; stall_d2 = 1'b0; pop_last = 1'b0; rsp_last_v = 1'b0;
  endtask

  task automatic start_run(input t_cci_clAddr addr, input int num, input int s);
    sel = s; depth_cur = (s == 1) ? 4 : 64;
    start_cur = addr; num_cur = num;
    reqs = 0; pops_applied = 0; first_req = -1; last_req = -1;
    rd_start_addr = addr; rd_num_cls = num; afu_state = AFU_RUN;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_valid"}, m_rd_valid, 1'b0);
    chk({tag, "_out_valid"}, m_out_valid, 1'b0);
    chk({tag, "_rd_done"}, m_rd_done, 1'b0);
    chk({tag, "_rd_addr"}, m_rd_addr, '0);
    chk({tag, "_rd_mdata"}, m_rd_mdata, '0);
    chk({tag, "_out_idx"}, m_out_idx, '0);
    chk({tag, "_out_data_zero"}, m_out_data == '0, 1'b1);
    chk({tag, "_run_cls_rcvd"}, m_rcls, '0);
  endtask

  task automatic run_to_end(input int exp_reqs, input logic exp_done, input int exp_rcvd, input int exp_span);
    int idle, r;
    idle = 0;
    for (int g = 0; g < 4000 && reqs < num_cur && idle < 40; g++) begin
      r = reqs;
      tick();
      idle = (reqs == r) ? idle + 1 : 0;
    end
    afu_state = AFU_DONE;
    for (int g = 0; g < 2000 && (pend.size() > 0 || rsp_last_v); g++) tick();
    chk("drain_all_responses", pend.size(), 0);
    tick(); tick();
    chk("total_requests", reqs, exp_reqs);
    chk("rd_done", m_rd_done, exp_done);
    chk("run_cls_rcvd", m_rcls, exp_rcvd);
    if (exp_span >= 0) chk("request_span", last_req - first_req, exp_span);
    afu_state = AFU_CTRL;
    tick(); tick();
    chk("run_cls_rcvd_hold", m_rcls, exp_rcvd);
  endtask

  typedef struct {
    t_cci_clAddr start;
    int num, s, rmode, pmode, spct, ereq;
    logic edone;
    int ercv, span;
  } vec_t;

  initial begin
    vec_t vt[5];
    int order[4];
    int k, n, s, pm, ex;

    vt[0] = '{42'h1000,         4,  0, 1, 0, 0,  4,  1'b1, 4,  3};
    vt[1] = '{42'h3FF_FFFF_FFFE, 5,  0, 2, 1, 30, 5,  1'b1, 5,  -1};
    vt[2] = '{42'h20,           20, 1, 2, 1, 20, 20, 1'b1, 20, -1};
    vt[3] = '{42'h500,          70, 0, 1, 0, 0,  64, 1'b0, 64, 63};
    vt[4] = '{42'h7000,         9,  1, 1, 0, 0,  4,  1'b0, 4,  3};
    order = '{2, 0, 3, 1};

    rst_n = 1'b1; afu_state = AFU_CTRL; stall = 1'b0; rd_start_addr = '0; rd_num_cls = '0;
    rsp_valid = 1'b0; rsp_mdata = '0; rsp_data = '0; out_pop = 1'b0;
    #2 rst_n = 1'b0;
    #2 chk_zero("reset");
    sel = 1;
    #1 chk_zero("reset_small");
    sel = 0;

    for (int v = 0; v < 5; v++) begin
      do_reset();
      rsp_mode = vt[v].rmode; pop_mode = vt[v].pmode; stall_pct = vt[v].spct;
      start_run(vt[v].start, vt[v].num, vt[v].s);
      run_to_end(vt[v].ereq, vt[v].edone, vt[v].ercv, vt[v].span);
    end

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 40); s = $urandom_range(0, 1); pm = $urandom_range(0, 1);
      ex = (pm == 1 || n <= ((s == 1) ? 4 : 64)) ? n : ((s == 1) ? 4 : 64);
      do_reset();
      rsp_mode = $urandom_range(1, 2); pop_mode = pm; stall_pct = $urandom_range(0, 30);
      start_run(t_cci_clAddr'({$urandom(), $urandom()}), n, s);
      run_to_end(ex, ex == n, ex, -1);
    end

    // Credit exhaustion on the depth-4 instance, then two pops release two more requests.
    do_reset(); rsp_mode = 1;
    start_run(42'h40, 8, 1);
    repeat (20) tick();
    chk("credit_block_reqs", reqs, 4);
    pop_mode = 2; pop_budget = 2;
    repeat (20) tick();
    chk("credit_return_reqs", reqs, 6);

    // Stall after the second request for five cycles.
    do_reset(); rsp_mode = 1; pop_mode = 1;
    start_run(42'h2000, 6, 0);
    for (int g = 0; g < 50 && reqs < 2; g++) tick();
    stall_force = 1'b1; stall_reqs = 0;
    repeat (5) tick();
    stall_force = 1'b0;
    chk("reqs_during_stall_le1", stall_reqs <= 1, 1'b1);
    run_to_end(6, 1'b1, 6, -1);

    // Out-of-order responses 2,0,3,1.
    do_reset(); pop_mode = 1;
    start_run(42'h3000, 4, 0);
    for (int g = 0; g < 50 && reqs < 4; g++) tick();
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      k = -1;
      for (int j = 0; j < pend.size(); j++) if (pend[j].idx == order[i]) k = j;
      chk("reorder_pending", k >= 0, 1'b1);
      if (k >= 0) send(k);
      tick();
      chk("reorder_rd_done", m_rd_done, i == 3);
    end
    chk("reorder_run_cls_rcvd", m_rcls, 4);

    // Abort after five requests; pending responses still forwarded, then back to IDLE.
    do_reset(); pop_mode = 1;
    start_run(42'h5000, 10, 0);
    for (int g = 0; g < 50 && reqs < 5; g++) tick();
    afu_state = AFU_CTRL;
    repeat (6) tick();
    chk("abort_reqs", reqs, 5);
    for (int g = 0; g < 20 && pend.size() > 0; g++) begin
      send(0);
      tick();
    end
    tick();
    chk("abort_run_cls_rcvd", m_rcls, 5);
    chk("abort_rd_done", m_rd_done, 1'b0);
    tick();
    rsp_mode = 1;
    start_run(42'h9000, 1, 0);
    tick();
    chk("rerun_rcvd_cleared", m_rcls, 0);
    run_to_end(1, 1'b1, 1, 0);

    // Zero-length run.
    do_reset();
    start_run(42'h77, 0, 0);
    tick();
    chk("zero_len_done_early", m_rd_done, 1'b0);
    tick();
    chk("zero_len_done", m_rd_done, 1'b1);
    repeat (3) tick();
    chk("zero_len_reqs", reqs, 0);

    // Asynchronous reset mid-run, then credits restored to full depth.
    do_reset(); rsp_mode = 1;
    start_run(42'h1000, 4, 0);
    for (int g = 0; g < 50 && reqs < 2; g++) tick();
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    do_reset(); rsp_mode = 1;
    start_run(42'h100, 70, 0);
    run_to_end(64, 1'b0, 64, 63);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/read_engine.md
Name: read_engine

Overview:
- Read-side counterpart of the write engine; streams a contiguous block of cache lines from host memory into the AFU.
- During AFU_RUN it issues CCI read requests starting at a programmed address.
- It forwards each read response, tagged with its line index, to a downstream FIFO.
- Issue is throttled by a credit counter that tracks free space in that FIFO.
- It reports run completion and the received-line count for the status cache line.

Parameters:
OUT_FIFO_DEPTH, 64, depth of the downstream data FIFO; initial and maximum credit count (power of 2, 2..1024)
MDATA_W, 16, width of the request/response mdata tag carrying the line index

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
afu_state  in  e_afu_state  global AFU state (AFU_CTRL, AFU_RUN, AFU_DONE, others)
stall  in  1  request channel almost-full; block must tolerate 3 more requests after assertion
rd_start_addr  in  t_cci_clAddr  first cache-line address of the run
rd_num_cls  in  32  number of cache lines to read in the run
rd_valid  out  1  read request valid (one cycle per request)
rd_addr  out  t_cci_clAddr  read request cache-line address
rd_mdata  out  MDATA_W  request tag = line index mod 2^MDATA_W
rsp_valid  in  1  read response valid
rsp_mdata  in  MDATA_W  tag returned with the response
rsp_data  in  t_cci_clData  response cache line (512 bits)
out_valid  out  1  push strobe to the downstream FIFO
out_idx  out  MDATA_W  line index of out_data
out_data  out  t_cci_clData  forwarded cache line
out_pop  in  1  downstream consumer popped one entry (returns one credit)
rd_done  out  1  level; all rd_num_cls responses received in the current run
run_cls_rcvd  out  32  responses received in the last or current run

Behaviour:
- Reset (rst_n low, asynchronous) drives:
  - rd_valid, out_valid and rd_done to 0.
  - rd_addr, rd_mdata, out_idx, out_data and run_cls_rcvd to 0.
  - The state to IDLE and the credit count to OUT_FIFO_DEPTH.
- Registers:
  - issued (32 bits): requests sent in this run.
  - rcvd (32 bits): responses received in this run.
  - credits (log2(OUT_FIFO_DEPTH)+1 bits).
  - Latched copies of start_addr and num_cls.
- State machine:
  - IDLE -> ISSUE when afu_state == AFU_RUN.
    - Latch rd_start_addr and rd_num_cls.
    - Clear issued, rcvd and rd_done.
  - ISSUE:
    - A request is sent in a cycle when ~stall, credits > 0 and issued < num_cls.
    - On the next clock: rd_valid=1, rd_addr = start_addr + issued (wraps modulo address width), rd_mdata = issued[MDATA_W-1:0]; issued increments.
    - -> WAIT when issued reaches num_cls.
    - -> WAIT immediately if afu_state leaves AFU_RUN; no further requests are sent.
  - WAIT:
    - No requests.
    - rd_done=1 when rcvd == num_cls.
    - -> IDLE when afu_state is neither AFU_RUN nor AFU_DONE and rcvd == issued (all outstanding responses drained).
  - num_cls == 0: ISSUE -> WAIT on its first cycle; rd_done=1 two cycles after AFU_RUN is first seen; zero requests.
- Response path, independent of state:
  - Latency is 1 cycle.
  - rsp_valid causes, on the next clock: out_valid=1, out_idx=rsp_mdata, out_data=rsp_data; rcvd increments.
  - Responses may arrive out of order; the block does not reorder them.
  - Responses arriving after leaving AFU_RUN are still forwarded and counted.
- Credits:
  - A request decrements credits; out_pop increments credits.
  - Both in the same cycle: credits unchanged.
  - credits == 0: issue stalls, and the response path is never blocked.
  - Credits must never exceed OUT_FIFO_DEPTH; the verification engineer asserts this.
- run_cls_rcvd:
  - Mirrors rcvd every cycle.
  - Holds its value in IDLE until the next entry to ISSUE, where it clears to 0.
- Stall: in-flight registered requests may still appear for up to 1 cycle after stall asserts, within the 3-request allowance.
- Reset mid-run: all state is discarded and credits restore to OUT_FIFO_DEPTH. Responses after reset are still forwarded but are not meaningful to the run.

Test Plan:
1. start=0x1000, num=4, no stall, depth 64, rsp returned 2 cycles after each request -> rd_addr 0x1000..0x1003 on 4 consecutive cycles, mdata 0..3; out_idx 0..3; rd_done=1, run_cls_rcvd=4.
2. num=8, depth=4, no out_pop -> exactly 4 requests, then rd_valid stays 0; pulse out_pop twice -> exactly 2 more requests (mdata 4,5).
3. num=6; stall asserted after the 2nd request for 5 cycles -> at most 1 additional rd_valid during stall; total 6 requests, addresses contiguous, none duplicated.
4. num=4, responses returned in order 2,0,3,1 -> out_idx sequence 2,0,3,1 with matching data; rd_done rises only after the 4th response.
5. num=10; afu_state -> AFU_CTRL after 5 requests -> no further requests; the 5 pending responses are forwarded; run_cls_rcvd=5; state returns to IDLE after the last response.
6. num=0 -> no rd_valid, rd_done=1 two cycles after AFU_RUN; rst_n pulsed low mid-run in scenario 1 -> all outputs 0 immediately (asynchronously), credits=64.
